// File: rtl/serial_frame_rx_if.sv
// Framer bundle: qualified serial bit stream in, byte stream with valid/ready out,
// plus lock and error pulses.
interface serial_frame_rx_if;
    logic       ENB;
    logic       S_OUT;
    logic       READY;
    logic [7:0] DATA;
    logic       VALID;
    logic       LOCK;
    logic       PERR;
    logic       OVERRUN;

    modport master (
        input  ENB, S_OUT, READY,
        output DATA, VALID, LOCK, PERR, OVERRUN
    );

    modport slave (
        output ENB, S_OUT, READY,
        input  DATA, VALID, LOCK, PERR, OVERRUN
    );
endinterface

// File: rtl/serial_frame_rx.sv
// Receive framer: hunts SYNC on the ENB-qualified bit stream, assembles an MSB-first
// byte, checks even parity and queues good bytes in a 2-entry FIFO drained by valid/ready.
module serial_frame_rx #(
    parameter logic [3:0] SYNC = 4'b1010
) (
    input  logic              CLK,
    input  logic              RESET_N,
    serial_frame_rx_if.master bus
);

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_DATA,
        ST_PAR
    } state_t;

    state_t     state;
    logic [3:0] window;
    logic [2:0] bit_cnt;
    logic [7:0] shift;

    logic [7:0] entry0;
    logic [7:0] entry1;
    logic [1:0] count;
    logic       valid_q;
    logic       lock_q;
    logic       perr_q;
    logic       ovr_q;

    logic [3:0] window_next;
    logic       par_edge;
    logic       par_ok;
    logic       push;
    logic       pop;
    logic       drop;
    logic [7:0] entry0_next;
    logic [7:0] entry1_next;
    logic [1:0] count_next;

    assign window_next = {window[2:0], bus.S_OUT};

    // entry0 is always the head; it is left untouched when the last byte leaves,
    // so DATA keeps showing the most recent byte while empty.
    always_comb begin
        par_edge    = bus.ENB && (state == ST_PAR);
        par_ok      = ((^shift) == bus.S_OUT);
        push        = par_edge && par_ok;
        pop         = (count != 2'd0) && bus.READY;
        drop        = 1'b0;
        entry0_next = entry0;
        entry1_next = entry1;
        count_next  = count;

        if (push && pop) begin
            if (count == 2'd2) begin
                entry0_next = entry1;
                entry1_next = shift;
            end else begin
                entry0_next = shift;
            end
        end else if (push) begin
            case (count)
                2'd0: begin
                    entry0_next = shift;
                    count_next  = 2'd1;
                end
                2'd1: begin
                    entry1_next = shift;
                    count_next  = 2'd2;
                end
                default: drop = 1'b1;
            endcase
        end else if (pop) begin
            if (count == 2'd2) begin
                entry0_next = entry1;
            end
            count_next = count - 2'd1;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state   <= ST_HUNT;
            window  <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            entry0  <= '0;
            entry1  <= '0;
            count   <= '0;
            valid_q <= 1'b0;
            lock_q  <= 1'b0;
            perr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            entry0  <= entry0_next;
            entry1  <= entry1_next;
            count   <= count_next;
            valid_q <= (count_next != 2'd0);
            perr_q  <= par_edge && !par_ok;
            ovr_q   <= drop;

            if (bus.ENB) begin
                unique case (state)
                    ST_HUNT: begin
                        window <= window_next;
                        if (window_next == SYNC) begin
                            state   <= ST_DATA;
                            bit_cnt <= '0;
                            lock_q  <= 1'b1;
                        end
                    end
                    ST_DATA: begin
                        shift   <= {shift[6:0], bus.S_OUT};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= ST_PAR;
                        end
                    end
                    ST_PAR: begin
                        // Fresh window so the next frame needs four new sync bits.
                        window <= '0;
                        state  <= ST_HUNT;
                        lock_q <= 1'b0;
                    end
                    default: begin
                        window <= '0;
                        state  <= ST_HUNT;
                        lock_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.DATA    = entry0;
    assign bus.VALID   = valid_q;
    assign bus.LOCK    = lock_q;
    assign bus.PERR    = perr_q;
    assign bus.OVERRUN = ovr_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Scoreboard bench for serial_frame_rx: frame-level reference model with a queue FIFO,
// directed scenarios followed by randomized frames, gaps and consumer back-pressure.
module tb_serial_frame_rx;

    localparam logic [3:0] SYNC_P = 4'b1010;

    logic CLK = 1'b0;
    logic RESET_N = 1'b1;

    serial_frame_rx_if bus();

    serial_frame_rx #(.SYNC(SYNC_P)) dut (
        .CLK    (CLK),
        .RESET_N(RESET_N),
        .bus    (bus)
    );

    always #5 CLK = ~CLK;

    int unsigned n_checks = 0;
    int unsigned n_err    = 0;

    // Reference model state: FIFO contents and the scoreboard of bytes still to transfer.
    logic [7:0] mdl_fifo[$];
    logic [7:0] exp_q[$];
    logic       m_sync = 1'b0;
    logic       m_par  = 1'b0;
    logic       m_pbit = 1'b0;
    logic [7:0] m_byte = '0;
    logic       exp_lock = 1'b0;
    logic       exp_perr = 1'b0;
    logic       exp_ovr  = 1'b0;
    logic [7:0] last_data = '0;
    logic       rnd_ready = 1'b0;
    logic       gaps      = 1'b0;
    logic       pop_m;
    logic       push_m;
    logic [7:0] xfer_b;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        mdl_fifo.delete();
        exp_q.delete();
        exp_lock  = 1'b0;
        exp_perr  = 1'b0;
        exp_ovr   = 1'b0;
        last_data = '0;
        m_sync    = 1'b0;
        m_par     = 1'b0;
    endfunction

    // Frame-level model: applies the rules at each clock edge using marks from stimulus.
    always @(posedge CLK) begin
        if (RESET_N) begin
            pop_m    = bus.READY && (mdl_fifo.size() != 0);
            push_m   = 1'b0;
            exp_perr = 1'b0;
            exp_ovr  = 1'b0;
            if (m_par) begin
                exp_lock = 1'b0;
                if (m_pbit == ^m_byte) begin
                    if (mdl_fifo.size() >= 2 && !pop_m) exp_ovr = 1'b1;
                    else push_m = 1'b1;
                end else begin
                    exp_perr = 1'b1;
                end
            end
            if (m_sync) exp_lock = 1'b1;
            if (pop_m) void'(mdl_fifo.pop_front());
            if (push_m) begin
                mdl_fifo.push_back(m_byte);
                exp_q.push_back(m_byte);
            end
        end
    end

    // Monitor: compares outputs on the falling edge, pops the scoreboard on transfers.
    always @(negedge CLK) begin
        if (RESET_N) begin
            chk("valid", {7'b0, bus.VALID}, {7'b0, (mdl_fifo.size() != 0)});
            if (mdl_fifo.size() != 0) chk("data_head", bus.DATA, mdl_fifo[0]);
            else                      chk("data_hold", bus.DATA, last_data);
            if (bus.VALID && bus.READY) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL xfer: got %02h expected no transfer at %0t", bus.DATA, $time);
                end else begin
                    xfer_b = exp_q.pop_front();
                    chk("xfer", bus.DATA, xfer_b);
                    last_data = xfer_b;
                end
            end
            chk("perr", {7'b0, bus.PERR}, {7'b0, exp_perr});
            chk("overrun", {7'b0, bus.OVERRUN}, {7'b0, exp_ovr});
            chk("lock", {7'b0, bus.LOCK}, {7'b0, exp_lock});
        end
    end

    task automatic step(input logic en, input logic b, input logic sync_m, input logic par_m);
        bus.ENB   = en;
        bus.S_OUT = b;
        m_sync    = sync_m;
        m_par     = par_m;
        if (rnd_ready) bus.READY = ($urandom_range(0, 2) == 0);
        @(posedge CLK);
        #1;
        m_sync = 1'b0;
        m_par  = 1'b0;
    endtask

    task automatic send_bit(input logic b, input logic sync_m, input logic par_m);
        if (gaps) step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        step(1'b1, b, sync_m, par_m);
    endtask

    task automatic send_sync();
        logic [3:0] s;
        s = SYNC_P;
        for (int i = 3; i >= 0; i--) send_bit(s[i], (i == 0), 1'b0);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic rdy_on_par);
        send_sync();
        for (int i = 7; i >= 0; i--) send_bit(d[i], 1'b0, 1'b0);
        m_byte = d;
        m_pbit = (^d) ^ bad_par;
        if (gaps) step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        if (rdy_on_par) bus.READY = 1'b1;
        step(1'b1, m_pbit, 1'b0, 1'b1);
    endtask

    task automatic drain();
        rnd_ready = 1'b0;
        bus.READY = 1'b1;
        for (int k = 0; k < 8 && mdl_fifo.size() != 0; k++) step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("drain_empty", {7'b0, bus.VALID}, 8'h00);
        bus.READY = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ENB   = 1'b0;
        bus.S_OUT = 1'b0;
        bus.READY = 1'b0;
        #1 RESET_N = 1'b0;
        #1;
        chk("rst_data", bus.DATA, 8'h00);
        chk("rst_valid", {7'b0, bus.VALID}, 8'h00);
        chk("rst_lock", {7'b0, bus.LOCK}, 8'h00);
        chk("rst_perr", {7'b0, bus.PERR}, 8'h00);
        chk("rst_ovr", {7'b0, bus.OVERRUN}, 8'h00);
        @(posedge CLK);
        #1 RESET_N = 1'b1;

        // Single good frame, consumer stalled.
        send_frame(8'hA5, 1'b0, 1'b0);
        chk("s1_data", bus.DATA, 8'hA5);
        chk("s1_valid", {7'b0, bus.VALID}, 8'h01);
        chk("s1_perr", {7'b0, bus.PERR}, 8'h00);
        drain();

        // Same frame with the parity bit flipped.
        send_frame(8'hA5, 1'b1, 1'b0);
        chk("s2_perr", {7'b0, bus.PERR}, 8'h01);
        chk("s2_valid", {7'b0, bus.VALID}, 8'h00);
        chk("s2_lock", {7'b0, bus.LOCK}, 8'h00);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("s2_perr_pulse", {7'b0, bus.PERR}, 8'h00);

        // Third good byte into a full FIFO is dropped.
        send_frame(8'h01, 1'b0, 1'b0);
        send_frame(8'h02, 1'b0, 1'b0);
        send_frame(8'h03, 1'b0, 1'b0);
        chk("s3_ovr", {7'b0, bus.OVERRUN}, 8'h01);
        chk("s3_head", bus.DATA, 8'h01);
        drain();
        chk("s3_last", bus.DATA, 8'h02);

        // ENB high every other cycle: 26 cycles per frame.
        gaps = 1'b1;
        send_frame(8'hA5, 1'b0, 1'b0);
        gaps = 1'b0;
        chk("s4_data", bus.DATA, 8'hA5);
        chk("s4_valid", {7'b0, bus.VALID}, 8'h01);

        // Reset mid-frame with a byte still queued.
        send_sync();
        for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)), 1'b0, 1'b0);
        bus.ENB = 1'b0;
        RESET_N = 1'b0;
        model_reset();
        #1;
        chk("s5_data", bus.DATA, 8'h00);
        chk("s5_valid", {7'b0, bus.VALID}, 8'h00);
        chk("s5_lock", {7'b0, bus.LOCK}, 8'h00);
        chk("s5_perr", {7'b0, bus.PERR}, 8'h00);
        chk("s5_ovr", {7'b0, bus.OVERRUN}, 8'h00);
        #3;
        #1 RESET_N = 1'b1;
        @(posedge CLK);
        #1;
        send_frame(8'h3C, 1'b0, 1'b0);
        chk("s5_after", bus.DATA, 8'h3C);
        chk("s5_after_v", {7'b0, bus.VALID}, 8'h01);
        drain();

        // Full FIFO, push and pop on the same edge.
        send_frame(8'h11, 1'b0, 1'b0);
        send_frame(8'h22, 1'b0, 1'b0);
        send_frame(8'h33, 1'b0, 1'b1);
        chk("s6_ovr", {7'b0, bus.OVERRUN}, 8'h00);
        chk("s6_head", bus.DATA, 8'h22);
        drain();
        chk("s6_last", bus.DATA, 8'h33);

        // Randomized frames, parity errors, gaps, idle bits and back-pressure.
        rnd_ready = 1'b1;
        for (int f = 0; f < 40; f++) begin
            logic idle_v;
            idle_v = 1'($urandom_range(0, 1));
            for (int k = 0; k < int'($urandom_range(0, 3)); k++) step(1'b1, idle_v, 1'b0, 1'b0);
            gaps = 1'($urandom_range(0, 1));
            send_frame(8'($urandom_range(0, 255)), ($urandom_range(0, 4) == 0), 1'b0);
            gaps = 1'b0;
        end
        drain();
        chk("sb_empty", 8'(exp_q.size()), 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/serial_frame_rx.md
# serial_frame_rx

Receive-side framer that sits directly downstream of the 4-bit shift register and consumes its serial output `S_OUT` while the register runs in a shift mode. It hunts for a 4-bit sync pattern, assembles the following 8 data bits MSB-first, checks an even-parity bit, and buffers good bytes in a 2-entry FIFO. The FIFO is drained through a valid/ready handshake. Bit sampling is qualified by the same `ENB` that enables the register, so the framer advances only when the register shifts.

## Interface
- `SYNC`, default 4'b1010: sync pattern, compared MSB-first (first received bit is bit 3).
- `CLK`  in  1  single clock; all state updates on the rising edge.
- `RESET_N`  in  1  asynchronous, active-low reset.
- `ENB`  in  1  bit-valid qualifier; `S_OUT` is sampled only on edges where `ENB`=1.
- `S_OUT`  in  1  serial bit from the shift register.
- `READY`  in  1  consumer accepts the head byte.
- `DATA`  out  8  FIFO head byte.
- `VALID`  out  1  FIFO not empty.
- `LOCK`  out  1  framer is not in HUNT.
- `PERR`  out  1  one-cycle pulse: parity mismatch; the byte is dropped.
- `OVERRUN`  out  1  one-cycle pulse: good byte dropped because the FIFO was full.

## Operation
- Reset (asynchronous, `RESET_N`=0):
  - State HUNT, sync window 4'b0000, bit counter 0, FIFO empty.
  - `DATA`=8'h00, and `VALID`, `LOCK`, `PERR`, `OVERRUN` all 0.
  - Takes effect immediately, including mid-frame; a partial frame is discarded.
- HUNT: on each enabled edge, window <= {window[2:0], `S_OUT`}. If {window[2:0], `S_OUT`} == `SYNC` on that edge, go to DATA with counter 0.
- DATA: on each enabled edge, shift `S_OUT` into the 8-bit assembly register at the LSB (first bit ends up as bit 7). On the 8th bit (counter 7), go to PAR.
- PAR: on the enabled edge, compare `S_OUT` with XOR of the assembled byte (even parity over 9 bits).
  - Match: push the byte.
  - Mismatch: `PERR`=1 for the next cycle; no push.
  - Either way, return to HUNT with window cleared to 0000. A new frame needs 4 fresh sync bits.
- `ENB`=0: FSM, window, counter and assembly register hold. The FIFO pop path still operates.
- FIFO (depth 2):
  - Pop when `VALID`&`READY`.
  - Push on a good parity edge.
  - Full, push, and pop on the same edge: both occur, occupancy stays 2, ordering is preserved.
  - Full, push, no pop: new byte discarded, `OVERRUN`=1 for one cycle, stored bytes unchanged.
  - Pop when empty: never happens (`VALID`=0).
- `DATA` is the head entry when `VALID`=1. It holds its last value when empty (8'h00 after reset).
- `LOCK` = (state != HUNT).

## Timing
- Frame length is 13 enabled edges: 4 sync, 8 data, 1 parity.
- Byte visible on `DATA`/`VALID` in the cycle after the parity-sampling edge.
- `PERR` and `OVERRUN` assert in the cycle after the parity edge and last exactly one cycle.
- `LOCK` rises after the edge that completes sync. It falls after the parity edge.
- Handshake: a transfer occurs on a rising edge with `VALID`=`READY`=1. The next entry, if any, is presented in the following cycle. `READY` may be held high continuously.
- Fully synchronous except reset. No combinational path from `READY` to `VALID` or `DATA`.

## Test plan
- Reset then single frame with `ENB`=1 and `READY`=0:
  - Stimulus: bits 1,0,1,0 | 1,0,1,0,0,1,0,1 | 0.
  - Required: `LOCK`=1 after the 4th edge; `VALID`=1 and `DATA`=8'hA5 after the 13th edge; `PERR`=0.
- Parity error: same frame with parity bit 1 -> `PERR` one-cycle pulse after the 13th edge, `VALID` stays 0, `LOCK` back to 0.
- Overrun with `READY`=0:
  - Stimulus: frames 8'h01 (parity 1), 8'h02 (parity 1), 8'h03 (parity 0).
  - Required: `OVERRUN` pulse after the third frame; then `READY`=1 yields 8'h01 then 8'h02, then `VALID`=0.
- `ENB` gaps: frame 8'hA5 with `ENB` high every other cycle -> identical result to the first scenario, after 26 cycles.
- Reset mid-frame: after sync plus 4 data bits, pulse `RESET_N` low for a half cycle -> all outputs 0 immediately; a following frame 8'h3C (parity 0) gives `DATA`=8'h3C, `VALID`=1.
- Simultaneous push/pop while full:
  - Setup: FIFO holds 8'h11, 8'h22.
  - Stimulus: assert `READY` on the parity edge of frame 8'h33.
  - Required: 8'h11 transferred, no `OVERRUN`, subsequent outputs 8'h22, 8'h33.
